// File: rtl/_rr_reg_arb_pkg.sv
// Shared definitions for the round-robin register arbiter:
// command encodings and FSM state type.
package _rr_reg_arb_pkg;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/_rr_pick.sv
// Combinational rotating-priority picker: first set req bit
// scanning upward from ptr, wrapping modulo NREQ.
module _rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic            valid_o
);

   // scan NREQ positions starting at ptr; first hit wins
   always_comb begin
      int idx;
      idx     = 0;
      win_o   = '0;
      valid_o = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (!valid_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/_rr_reg_arb.sv
// Round-robin arbiter sequencing LOAD/SET/CLEAR/TOGGLE commands
// onto one shared register. Optional txn_cnt via RR_REG_ARB_STATS_EN.
module _rr_reg_arb
   import _rr_reg_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] din,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [WIDTH-1:0]      q
`ifdef RR_REG_ARB_STATS_EN
   ,output logic [7:0]           txn_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   win_q, win_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [NREQ-1:0]   pick;
   logic              pick_v;
   logic [PW-1:0]     win_idx;
   logic [1:0]        op_sel;
   logic [WIDTH-1:0]  din_sel;
   logic              commit;

   _rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .win_o   (pick),
      .valid_o (pick_v)
   );

   // one-hot winner to index for operand select and ptr update
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_q[i]) win_idx = PW'(i);
      end
   end

   assign op_sel  = op[2*int'(win_idx) +: 2];
   assign din_sel = din[WIDTH*int'(win_idx) +: WIDTH];
   assign commit  = (state_q == ST_GRANT) && |(req & win_q);

   // next state; win_q is zero outside GRANT so it drives gnt directly
   always_comb begin
      state_d = ST_IDLE;
      win_d   = '0;
      ptr_d   = ptr_q;
      q_d     = q_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_v) begin
               state_d = ST_GRANT;
               win_d   = pick;
            end
         end
         ST_GRANT: begin
            if (commit) begin
               ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
               unique case (op_sel)
                  OP_LOAD:   q_d = din_sel;
                  OP_SET:    q_d = '1;
                  OP_CLEAR:  q_d = '0;
                  OP_TOGGLE: q_d = ~q_q;
               endcase
            end
         end
      endcase
   end

   // state, winner, pointer and shared register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         ptr_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         q_q     <= q_d;
      end
   end

   assign gnt  = win_q;
   assign busy = (state_q == ST_GRANT);
   assign q    = q_q;

`ifdef RR_REG_ARB_STATS_EN
   logic [7:0] cnt_q;

   // completed-transaction count, wraps naturally at 8 bits
   always_ff @(posedge clk) begin
      if (reset)       cnt_q <= '0;
      else if (commit) cnt_q <= cnt_q + 8'd1;
   end

   assign txn_cnt = cnt_q;
`endif

endmodule

// File: tb/tb__rr_reg_arb.sv
// Self-checking bench for _rr_reg_arb (WIDTH=8, NREQ=4) with a
// behavioural model compared every cycle plus directed checks.
module tb__rr_reg_arb;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [2*N-1:0] op = '0;
   logic [W*N-1:0] din = '0;
   logic [N-1:0]   gnt;
   logic           busy;
   logic [W-1:0]   q;
`ifdef RR_REG_ARB_STATS_EN
   logic [7:0]     txn_cnt;
`endif

   _rr_reg_arb #(.WIDTH(W), .NREQ(N)) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .op    (op),
      .din   (din),
      .gnt   (gnt),
      .busy  (busy),
      .q     (q)
`ifdef RR_REG_ARB_STATS_EN
      ,.txn_cnt (txn_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // behavioural model: granted requester (-1 none), register, ptr, count
   int         m_g = -1;
   logic [W-1:0] m_q = '0;
   int         m_ptr = 0;
   int         m_cnt = 0;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_g = -1; m_q = '0; m_ptr = 0; m_cnt = 0; chk_en = 1'b1;
      end else if (m_g >= 0) begin
         if (req[m_g]) begin
            case (op[2*m_g +: 2])
               2'd0: m_q = din[W*m_g +: W];
               2'd1: m_q = 8'hFF;
               2'd2: m_q = 8'h00;
               default: m_q = ~m_q;
            endcase
            m_ptr = (m_g + 1) % N;
            m_cnt = (m_cnt + 1) % 256;
         end
         m_g = -1;
      end else begin
         bit found;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               m_g = (m_ptr + k) % N;
               found = 1'b1;
            end
         end
      end
   end

   // compare DUT against the model mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("gnt", 32'(gnt), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
         chk("busy", 32'(busy), 32'(m_g >= 0));
         chk("q", 32'(q), 32'(m_q));
`ifdef RR_REG_ARB_STATS_EN
         chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
`endif
      end
   end

   int order[$];
   int gtime[$];
   int busy_cyc;

   task automatic set_cmd(input int i, input logic [1:0] o,
                          input logic [W-1:0] d);
      op[2*i +: 2] = o;
      din[W*i +: W] = d;
   endtask

   // raise mask; each requester drops req the cycle after its grant
   task automatic serve(input logic [N-1:0] mask);
      logic [N-1:0] prevg;
      int n;
      prevg = '0;
      n = 0;
      req = mask;
      while (req != '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
         req = req & ~prevg;
         prevg = gnt;
         if (busy) busy_cyc++;
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
               order.push_back(i);
               gtime.push_back(cyc);
            end
         end
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL serve_timeout: got req %0h expected 0", req);
         req = '0;
      end
   endtask

   task automatic wait_gnt(input int i);
      int n;
      n = 0;
      while (!gnt[i] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!gnt[i]) begin
         errors++;
         $display("FAIL wait_gnt%0d: got gnt %0h expected bit set", i, gnt);
      end
   endtask

   int t0;
   logic [7:0] c0;

   initial begin
      // reset held for two cycles
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
`ifdef RR_REG_ARB_STATS_EN
      chk("rst_cnt", 32'(txn_cnt), 32'h0);
`endif
      reset = 1'b0;

      // contention: all four LOAD, grants 0,1,2,3 two cycles apart
      for (int i = 0; i < N; i++) set_cmd(i, 2'b00, 8'(8'h11 * (i + 1)));
      order.delete(); gtime.delete();
      serve(4'b1111);
      chk("cont_n", 32'(order.size()), 32'd4);
      for (int i = 0; i < order.size() && i < 4; i++) begin
         chk("cont_ord", 32'(order[i]), 32'(i));
         if (i > 0) chk("cont_gap", 32'(gtime[i] - gtime[i-1]), 32'd2);
      end
      chk("cont_q", 32'(q), 32'h44);
      order.delete();
      serve(4'b0001);
      chk("wrap_ord", 32'(order[0]), 32'd0);

      // single LOAD on requester 1
      set_cmd(1, 2'b00, 8'hA5);
      order.delete(); gtime.delete(); busy_cyc = 0;
      t0 = cyc;
      serve(4'b0010);
      chk("load_ord", 32'(order[0]), 32'd1);
      chk("load_lat", 32'(gtime[0] - t0), 32'd1);
      chk("load_q", 32'(q), 32'hA5);
      chk("load_busy", 32'(busy_cyc), 32'd1);

      // commands
      set_cmd(2, 2'b01, 8'h00); serve(4'b0100);
      chk("set_q", 32'(q), 32'hFF);
      set_cmd(3, 2'b10, 8'h5A); serve(4'b1000);
      chk("clr_q", 32'(q), 32'h00);
      set_cmd(0, 2'b00, 8'h0F); serve(4'b0001);
      set_cmd(1, 2'b11, 8'h00); serve(4'b0010);
      chk("tog_q", 32'(q), 32'hF0);

      // withdrawal with ptr at 1
      set_cmd(0, 2'b00, 8'h3C); serve(4'b0001);
`ifdef RR_REG_ARB_STATS_EN
      c0 = txn_cnt;
`endif
      set_cmd(1, 2'b00, 8'h77);
      req = 4'b0010;
      wait_gnt(1);
      req = '0;
      @(posedge clk); #1;
      chk("wd_q", 32'(q), 32'h3C);
      chk("wd_busy", 32'(busy), 32'h0);
`ifdef RR_REG_ARB_STATS_EN
      chk("wd_cnt", 32'(txn_cnt), 32'(c0));
`endif
      set_cmd(2, 2'b10, 8'h00);
      order.delete();
      serve(4'b0110);
      chk("wd_ord0", 32'(order[0]), 32'd1);
      chk("wd_ord1", 32'(order[1]), 32'd2);
      chk("wd_q2", 32'(q), 32'h00);

      // reset in a GRANT cycle: no command, ptr back to 0
      set_cmd(0, 2'b00, 8'h81); serve(4'b0001);
      set_cmd(2, 2'b01, 8'h00);
      req = 4'b0100;
      wait_gnt(2);
      reset = 1'b1;
      req = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rg_q", 32'(q), 32'h00);
      chk("rg_gnt", 32'(gnt), 32'h0);
      set_cmd(2, 2'b00, 8'h5A);
      set_cmd(3, 2'b00, 8'hC3);
      order.delete();
      serve(4'b1100);
      chk("rg_ord", 32'(order[0]), 32'd2);
      chk("rg_q2", 32'(q), 32'hC3);

`ifdef RR_REG_ARB_STATS_EN
      // counter wrap after 256 completed transactions
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("cw_rst", 32'(txn_cnt), 32'd0);
      set_cmd(0, 2'b11, 8'h00);
      for (int i = 0; i < 255; i++) serve(4'b0001);
      chk("cw_255", 32'(txn_cnt), 32'd255);
      serve(4'b0001);
      chk("cw_0", 32'(txn_cnt), 32'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
